// File: rtl/id_decode_interlock.sv
// Decode stage: register file, busy-register scoreboard with stall interlock, same-cycle BEQ/BNE resolution, ID/EX register.
// Optional writeback-to-operand forwarding is enabled by defining ID_WB_BYPASS_EN.
module id_decode_interlock #(
  parameter int DATA_W = 32
) (
  input  logic              CLK,
  input  logic              resetn,
  input  logic [31:0]       instruction,
  input  logic              instr_valid,
  input  logic              wb_en,
  input  logic [4:0]        wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic              PCSrc,
  output logic              stall,
  output logic              idex_valid,
  output logic [5:0]        idex_opcode,
  output logic [5:0]        idex_funct,
  output logic [DATA_W-1:0] idex_rs_val,
  output logic [DATA_W-1:0] idex_rt_val,
  output logic [DATA_W-1:0] idex_imm,
  output logic [4:0]        idex_dest
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  logic [DATA_W-1:0] r_regs [32];
  logic [31:0]       r_busy;

  logic [5:0]        w_opcode;
  logic [4:0]        w_rs;
  logic [4:0]        w_rt;
  logic [4:0]        w_rd;
  logic              w_use_rs;
  logic              w_use_rt;
  logic [4:0]        w_dest;
  logic              w_rs_fwd;
  logic              w_rt_fwd;
  logic [DATA_W-1:0] w_rs_val;
  logic [DATA_W-1:0] w_rt_val;
  logic [DATA_W-1:0] w_imm;
  logic              w_hazard;
  logic              w_accept;
  logic              w_take;
  logic [31:0]       w_set_vec;
  logic [31:0]       w_clr_vec;
  logic [31:0]       w_busy_nxt;

  assign w_opcode = instruction[31:26];
  assign w_rs     = instruction[25:21];
  assign w_rt     = instruction[20:16];
  assign w_rd     = instruction[15:11];
  assign w_imm    = {{(DATA_W-16){instruction[15]}}, instruction[15:0]};

  // Source usage and destination per opcode
  always_comb begin
    w_use_rs = 1'b0;
    w_use_rt = 1'b0;
    w_dest   = 5'd0;
    case (w_opcode)
      OP_RTYPE: begin
        w_use_rs = 1'b1;
        w_use_rt = 1'b1;
        w_dest   = w_rd;
      end
      OP_LW, OP_ADDI: begin
        w_use_rs = 1'b1;
        w_dest   = w_rt;
      end
      OP_SW, OP_BEQ, OP_BNE: begin
        w_use_rs = 1'b1;
        w_use_rt = 1'b1;
      end
      default: begin
        w_use_rs = 1'b0;
        w_use_rt = 1'b0;
        w_dest   = 5'd0;
      end
    endcase
  end

  // Writeback forwarding match; r0 is never forwarded
  always_comb begin
    w_rs_fwd = 1'b0;
    w_rt_fwd = 1'b0;
`ifdef ID_WB_BYPASS_EN
    w_rs_fwd = wb_en && (wb_addr == w_rs) && (w_rs != 5'd0);
    w_rt_fwd = wb_en && (wb_addr == w_rt) && (w_rt != 5'd0);
`endif
  end

  assign w_rs_val = (w_rs == 5'd0) ? {DATA_W{1'b0}} : (w_rs_fwd ? wb_data : r_regs[w_rs]);
  assign w_rt_val = (w_rt == 5'd0) ? {DATA_W{1'b0}} : (w_rt_fwd ? wb_data : r_regs[w_rt]);

  // A forwarded source is satisfied this cycle even though its busy bit is still set
  assign w_hazard = (w_use_rs && r_busy[w_rs] && !w_rs_fwd) ||
                    (w_use_rt && r_busy[w_rt] && !w_rt_fwd);
  assign w_accept = instr_valid && !w_hazard;
  assign w_take   = ((w_opcode == OP_BEQ) && (w_rs_val == w_rt_val)) ||
                    ((w_opcode == OP_BNE) && (w_rs_val != w_rt_val));

  assign stall = resetn && instr_valid && w_hazard;
  assign PCSrc = resetn && w_accept && w_take;

  // Set wins over clear so a same-cycle writeback cannot drop a fresh reservation
  assign w_set_vec  = (w_accept && (w_dest != 5'd0)) ? (32'd1 << w_dest) : 32'd0;
  assign w_clr_vec  = wb_en ? (32'd1 << wb_addr) : 32'd0;
  assign w_busy_nxt = w_set_vec | (r_busy & ~w_clr_vec);

  // Scoreboard register
  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      r_busy <= 32'd0;
    end else begin
      r_busy <= w_busy_nxt;
    end
  end

  // Register file; r0 stays zero because it is never written
  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < 32; i++) begin
        r_regs[i] <= {DATA_W{1'b0}};
      end
    end else if (wb_en && (wb_addr != 5'd0)) begin
      r_regs[wb_addr] <= wb_data;
    end
  end

  // ID/EX pipeline register; any non-accepted cycle loads an all-zero bubble
  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      idex_valid  <= 1'b0;
      idex_opcode <= 6'd0;
      idex_funct  <= 6'd0;
      idex_rs_val <= {DATA_W{1'b0}};
      idex_rt_val <= {DATA_W{1'b0}};
      idex_imm    <= {DATA_W{1'b0}};
      idex_dest   <= 5'd0;
    end else if (w_accept) begin
      idex_valid  <= 1'b1;
      idex_opcode <= w_opcode;
      idex_funct  <= instruction[5:0];
      idex_rs_val <= w_rs_val;
      idex_rt_val <= w_rt_val;
      idex_imm    <= w_imm;
      idex_dest   <= w_dest;
    end else begin
      idex_valid  <= 1'b0;
      idex_opcode <= 6'd0;
      idex_funct  <= 6'd0;
      idex_rs_val <= {DATA_W{1'b0}};
      idex_rt_val <= {DATA_W{1'b0}};
      idex_imm    <= {DATA_W{1'b0}};
      idex_dest   <= 5'd0;
    end
  end

endmodule

// File: tb/tb_id_decode_interlock.sv
// Directed-vector bench for id_decode_interlock; expectations follow ID_WB_BYPASS_EN when it is defined.
module tb_id_decode_interlock;

  logic        CLK;
  logic        resetn;
  logic [31:0] instruction;
  logic        instr_valid;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        PCSrc;
  logic        stall;
  logic        idex_valid;
  logic [5:0]  idex_opcode;
  logic [5:0]  idex_funct;
  logic [31:0] idex_rs_val;
  logic [31:0] idex_rt_val;
  logic [31:0] idex_imm;
  logic [4:0]  idex_dest;

  int n_vec;
  int n_err;

  id_decode_interlock #(.DATA_W(32)) dut (
    .CLK(CLK), .resetn(resetn), .instruction(instruction), .instr_valid(instr_valid),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .PCSrc(PCSrc), .stall(stall), .idex_valid(idex_valid), .idex_opcode(idex_opcode),
    .idex_funct(idex_funct), .idex_rs_val(idex_rs_val), .idex_rt_val(idex_rt_val),
    .idex_imm(idex_imm), .idex_dest(idex_dest)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic wb_write(input logic [4:0] a, input logic [31:0] d);
    wb_en = 1'b1; wb_addr = a; wb_data = d;
    tick();
    wb_en = 1'b0;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    resetn = 1'b0; instruction = 32'h1000_0000; instr_valid = 1'b1;
    wb_en = 1'b0; wb_addr = 5'd0; wb_data = 32'd0;
    #2;
    chk("rst_pcsrc", {31'd0, PCSrc}, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_valid", {31'd0, idex_valid}, 32'd0);
    chk("rst_dest", {27'd0, idex_dest}, 32'd0);
    tick(); tick();
    resetn = 1'b1; instr_valid = 1'b0;
    #1;

    // ADDI r1,r0,5
    instruction = 32'h2001_0005; instr_valid = 1'b1; #1;
    chk("t1_stall", {31'd0, stall}, 32'd0);
    tick();
    chk("t1_valid", {31'd0, idex_valid}, 32'd1);
    chk("t1_dest", {27'd0, idex_dest}, 32'd1);
    chk("t1_imm", idex_imm, 32'd5);
    chk("t1_opcode", {26'd0, idex_opcode}, 32'h08);

    // ADD r2,r1,r1 while r1 busy
    instruction = 32'h0021_1020; #1;
    chk("t2_stall", {31'd0, stall}, 32'd1);
    chk("t2_pcsrc", {31'd0, PCSrc}, 32'd0);
    tick();
    chk("t2_bub_valid", {31'd0, idex_valid}, 32'd0);
    chk("t2_bub_dest", {27'd0, idex_dest}, 32'd0);
    chk("t2_stall_hold", {31'd0, stall}, 32'd1);
    wb_en = 1'b1; wb_addr = 5'd1; wb_data = 32'd5; #1;
`ifdef ID_WB_BYPASS_EN
    chk("t2_wb_stall", {31'd0, stall}, 32'd0);
    tick();
    wb_en = 1'b0;
`else
    chk("t2_wb_stall", {31'd0, stall}, 32'd1);
    tick();
    wb_en = 1'b0; #1;
    chk("t2_bub2_valid", {31'd0, idex_valid}, 32'd0);
    chk("t2_post_stall", {31'd0, stall}, 32'd0);
    tick();
`endif
    chk("t2_valid", {31'd0, idex_valid}, 32'd1);
    chk("t2_rs_val", idex_rs_val, 32'd5);
    chk("t2_rt_val", idex_rt_val, 32'd5);
    chk("t2_dest", {27'd0, idex_dest}, 32'd2);
    chk("t2_funct", {26'd0, idex_funct}, 32'h20);

    // invalid slot with a dependent instruction on the bus; r2 written back meanwhile
    instruction = 32'h0042_1820; instr_valid = 1'b0;
    wb_en = 1'b1; wb_addr = 5'd2; wb_data = 32'd10; #1;
    chk("inv_stall", {31'd0, stall}, 32'd0);
    chk("inv_pcsrc", {31'd0, PCSrc}, 32'd0);
    tick();
    wb_en = 1'b0;
    chk("inv_valid", {31'd0, idex_valid}, 32'd0);

    // branches on r4=r5=7
    wb_write(5'd4, 32'd7);
    wb_write(5'd5, 32'd7);
    instruction = 32'h1085_0003; instr_valid = 1'b1; #1;
    chk("t3_beq_pc", {31'd0, PCSrc}, 32'd1);
    chk("t3_beq_stall", {31'd0, stall}, 32'd0);
    tick();
    chk("t3_beq_valid", {31'd0, idex_valid}, 32'd1);
    chk("t3_beq_dest", {27'd0, idex_dest}, 32'd0);
    chk("t3_beq_imm", idex_imm, 32'd3);
    instruction = 32'h1485_0003; #1;
    chk("t3_bne_pc", {31'd0, PCSrc}, 32'd0);
    tick();
    instr_valid = 1'b0;
    wb_write(5'd5, 32'h8000_0007);
    instruction = 32'h1485_0003; instr_valid = 1'b1; #1;
    chk("t3_bne_ne_pc", {31'd0, PCSrc}, 32'd1);
    instruction = 32'h1085_FFFD; #1;
    chk("t3_beq_ne_pc", {31'd0, PCSrc}, 32'd0);
    tick();
    chk("t3_neg_imm", idex_imm, 32'hFFFF_FFFD);

    // BEQ with busy rs
    instruction = 32'h2004_0009; #1;
    tick();
    instruction = 32'h1085_0003; #1;
    chk("t4_stall", {31'd0, stall}, 32'd1);
    chk("t4_pcsrc", {31'd0, PCSrc}, 32'd0);
    tick();
    chk("t4_bub_valid", {31'd0, idex_valid}, 32'd0);
    wb_en = 1'b1; wb_addr = 5'd4; wb_data = 32'h8000_0007; #1;
`ifdef ID_WB_BYPASS_EN
    chk("t4_wb_stall", {31'd0, stall}, 32'd0);
    chk("t4_wb_pcsrc", {31'd0, PCSrc}, 32'd1);
    tick();
    wb_en = 1'b0;
`else
    chk("t4_wb_stall", {31'd0, stall}, 32'd1);
    chk("t4_wb_pcsrc", {31'd0, PCSrc}, 32'd0);
    tick();
    wb_en = 1'b0; #1;
    chk("t4_post_stall", {31'd0, stall}, 32'd0);
    chk("t4_post_pcsrc", {31'd0, PCSrc}, 32'd1);
    tick();
`endif
    chk("t4_valid", {31'd0, idex_valid}, 32'd1);
    chk("t4_rs_val", idex_rs_val, 32'h8000_0007);

    // r0 write ignored
    instr_valid = 1'b0;
    wb_write(5'd0, 32'hDEAD_BEEF);
    instruction = 32'h0000_3820; instr_valid = 1'b1; #1;
    chk("t5_r0_stall", {31'd0, stall}, 32'd0);
    tick();
    chk("t5_r0_rs", idex_rs_val, 32'd0);
    chk("t5_r0_rt", idex_rt_val, 32'd0);
    chk("t5_r0_dest", {27'd0, idex_dest}, 32'd7);

    // same-cycle set and clear of r6
    instruction = 32'h2006_0001; wb_en = 1'b1; wb_addr = 5'd6; wb_data = 32'd3; #1;
    chk("t5_set_stall", {31'd0, stall}, 32'd0);
    tick();
    wb_en = 1'b0;
    chk("t5_set_dest", {27'd0, idex_dest}, 32'd6);
    instruction = 32'h00C0_4020; #1;
    chk("t5_busy6_stall", {31'd0, stall}, 32'd1);

    // asynchronous reset mid-stall
    #2;
    resetn = 1'b0; #1;
    chk("t6_rst_valid", {31'd0, idex_valid}, 32'd0);
    chk("t6_rst_dest", {27'd0, idex_dest}, 32'd0);
    chk("t6_rst_stall", {31'd0, stall}, 32'd0);
    chk("t6_rst_pcsrc", {31'd0, PCSrc}, 32'd0);
    tick();
    resetn = 1'b1; #1;
    chk("t6_rel_stall", {31'd0, stall}, 32'd0);
    tick();
    chk("t6_valid", {31'd0, idex_valid}, 32'd1);
    chk("t6_dest", {27'd0, idex_dest}, 32'd8);
    chk("t6_rs_cleared", idex_rs_val, 32'd0);

    // NOP opcode ignores its (busy) rs field
    instruction = 32'hFD00_0000; #1;
    chk("nop_stall", {31'd0, stall}, 32'd0);
    tick();
    chk("nop_valid", {31'd0, idex_valid}, 32'd1);
    chk("nop_dest", {27'd0, idex_dest}, 32'd0);
    chk("nop_opcode", {26'd0, idex_opcode}, 32'h3F);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
